basic_cpu_control_unit: RTL and testbench

- Timing/control sequencer for the 16-bit common-bus basic computer.
- Drives the 3-bit bus select, the memory read/write strobes and the AR/PC/IR/DR/AC register controls through fetch, decode, indirect and memory-reference execute.
- Register-reference and I/O instructions are NOPs, except HLT.
- Sits beside the bus mux and register file. Consumes IR contents and the DR==0 flag.

---
 rtl/basic_cpu_control_unit.sv | 180 ++++++++++++++++++
 tb/tb_basic_cpu_control_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/basic_cpu_control_unit.sv
// rtl/basic_cpu_control_unit.sv - timing/control sequencer for the 16-bit common-bus basic computer
module basic_cpu_control_unit #(
  parameter logic [15:0] HLT_CODE = 16'h7001,
  parameter int          SC_W     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     ir,
  input  logic            dr_zero,
  output logic [2:0]      s,
  output logic            read,
  output logic            write,
  output logic            ar_ld,
  output logic            ar_inr,
  output logic            ar_clr,
  output logic            pc_ld,
  output logic            pc_inr,
  output logic            pc_clr,
  output logic            ir_ld,
  output logic            dr_ld,
  output logic            dr_inr,
  output logic            ac_ld,
  output logic [1:0]      alu_op,
  output logic [SC_W-1:0] sc,
  output logic            i_flag,
  output logic            busy,
  output logic            halted
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [2:0] BUS_AR  = 3'd1;
  localparam logic [2:0] BUS_PC  = 3'd2;
  localparam logic [2:0] BUS_DR  = 3'd3;
  localparam logic [2:0] BUS_AC  = 3'd4;
  localparam logic [2:0] BUS_IR  = 3'd5;
  localparam logic [2:0] BUS_MEM = 3'd7;

  state_t          state;
  logic [SC_W-1:0] sc_q;
  logic            halted_q;
  logic            i_q;
  logic [2:0]      d_q;
  logic            sc_clr;
  logic            halt_now;

  // Decode the current timing step into datapath controls; everything is 0 unless running.
  always_comb begin
    s        = 3'd0;
    read     = 1'b0;
    write    = 1'b0;
    ar_ld    = 1'b0;
    ar_inr   = 1'b0;
    pc_ld    = 1'b0;
    pc_inr   = 1'b0;
    ir_ld    = 1'b0;
    dr_ld    = 1'b0;
    dr_inr   = 1'b0;
    ac_ld    = 1'b0;
    alu_op   = 2'b00;
    sc_clr   = 1'b0;
    halt_now = 1'b0;
    if (state == ST_RUN) begin
      case (sc_q)
        SC_W'(0): begin
          s     = BUS_PC;
          ar_ld = 1'b1;
        end
        SC_W'(1): begin
          s      = BUS_MEM;
          read   = 1'b1;
          ir_ld  = 1'b1;
          pc_inr = 1'b1;
        end
        SC_W'(2): begin
          s     = BUS_IR;
          ar_ld = 1'b1;
        end
        SC_W'(3): begin
          if (d_q == 3'd7) begin
            sc_clr   = 1'b1;
            halt_now = (ir == HLT_CODE);
          end else if (i_q) begin
            s     = BUS_MEM;
            read  = 1'b1;
            ar_ld = 1'b1;
          end
        end
        SC_W'(4): begin
          case (d_q)
            3'd0, 3'd1, 3'd2, 3'd6: begin
              s     = BUS_MEM;
              read  = 1'b1;
              dr_ld = 1'b1;
            end
            3'd3: begin
              s      = BUS_AC;
              write  = 1'b1;
              sc_clr = 1'b1;
            end
            3'd4: begin
              s      = BUS_AR;
              pc_ld  = 1'b1;
              sc_clr = 1'b1;
            end
            3'd5: begin
              s      = BUS_PC;
              write  = 1'b1;
              ar_inr = 1'b1;
            end
            default: ;
          endcase
        end
        SC_W'(5): begin
          case (d_q)
            3'd0, 3'd1, 3'd2: begin
              alu_op = d_q[1:0];
              ac_ld  = 1'b1;
              sc_clr = 1'b1;
            end
            3'd5: begin
              s      = BUS_AR;
              pc_ld  = 1'b1;
              sc_clr = 1'b1;
            end
            3'd6: dr_inr = 1'b1;
            default: ;
          endcase
        end
        SC_W'(6): begin
          if (d_q == 3'd6) begin
            s      = BUS_DR;
            write  = 1'b1;
            pc_inr = dr_zero;
            sc_clr = 1'b1;
          end
        end
        default: ;
      endcase
      // Guard against a runaway counter; legal flow never gets here.
      if (sc_q == {SC_W{1'b1}}) sc_clr = 1'b1;
    end
  end

  // Sequencer state: run/idle, step counter, halt flag and latched I/opcode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sc_q     <= '0;
      halted_q <= 1'b0;
      i_q      <= 1'b0;
      d_q      <= 3'd0;
    end else if (state == ST_IDLE) begin
      sc_q <= '0;
      if (start) begin
        state    <= ST_RUN;
        halted_q <= 1'b0;
      end
    end else begin
      if (sc_q == SC_W'(2)) begin
        d_q <= ir[14:12];
        i_q <= ir[15];
      end
      if (halt_now) begin
        state    <= ST_IDLE;
        halted_q <= 1'b1;
      end
      sc_q <= sc_clr ? '0 : sc_q + SC_W'(1);
    end
  end

  assign ar_clr = 1'b0;
  assign pc_clr = 1'b0;
  assign sc     = sc_q;
  assign i_flag = i_q;
  assign busy   = (state == ST_RUN);
  assign halted = halted_q;

endmodule

// File: tb/tb_basic_cpu_control_unit.sv
// tb/tb_basic_cpu_control_unit.sv - directed self-checking bench for basic_cpu_control_unit
module tb_basic_cpu_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ir = 16'h0000;
  logic        dr_zero = 1'b0;
  logic [2:0]  s;
  logic        read, write, ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr;
  logic        ir_ld, dr_ld, dr_inr, ac_ld;
  logic [1:0]  alu_op;
  logic [3:0]  sc;
  logic        i_flag, busy, halted;

  int checks = 0;
  int errors = 0;

  basic_cpu_control_unit dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir), .dr_zero(dr_zero),
    .s(s), .read(read), .write(write),
    .ar_ld(ar_ld), .ar_inr(ar_inr), .ar_clr(ar_clr),
    .pc_ld(pc_ld), .pc_inr(pc_inr), .pc_clr(pc_clr),
    .ir_ld(ir_ld), .dr_ld(dr_ld), .dr_inr(dr_inr), .ac_ld(ac_ld),
    .alu_op(alu_op), .sc(sc), .i_flag(i_flag), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // Packed view: [16:14] s, read, write, ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr,
  // ir_ld, dr_ld, dr_inr, ac_ld, [1:0] alu_op
  logic [16:0] ctrl;
  assign ctrl = {s, read, write, ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr,
                 ir_ld, dr_ld, dr_inr, ac_ld, alu_op};

  localparam logic [16:0] READ   = 17'h1 << 13;
  localparam logic [16:0] WRITE  = 17'h1 << 12;
  localparam logic [16:0] AR_LD  = 17'h1 << 11;
  localparam logic [16:0] AR_INR = 17'h1 << 10;
  localparam logic [16:0] PC_LD  = 17'h1 << 8;
  localparam logic [16:0] PC_INR = 17'h1 << 7;
  localparam logic [16:0] IR_LD  = 17'h1 << 5;
  localparam logic [16:0] DR_LD  = 17'h1 << 4;
  localparam logic [16:0] DR_INR = 17'h1 << 3;
  localparam logic [16:0] AC_LD  = 17'h1 << 2;
  localparam logic [16:0] S1 = 17'd1 << 14;
  localparam logic [16:0] S2 = 17'd2 << 14;
  localparam logic [16:0] S3 = 17'd3 << 14;
  localparam logic [16:0] S4 = 17'd4 << 14;
  localparam logic [16:0] S5 = 17'd5 << 14;
  localparam logic [16:0] S7 = 17'd7 << 14;

  localparam logic [16:0] C_T0  = S2 | AR_LD;
  localparam logic [16:0] C_T1  = S7 | READ | IR_LD | PC_INR;
  localparam logic [16:0] C_T2  = S5 | AR_LD;
  localparam logic [16:0] C_IND = S7 | READ | AR_LD;
  localparam logic [16:0] C_MRD = S7 | READ | DR_LD;

  logic [16:0] exp_q [0:6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample one instruction starting at its T0 cycle, comparing against exp_q.
  task automatic run_instr(input string name, input logic [15:0] ir_val,
                           input logic dz, input int len);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == 0) begin
        ir = ir_val;
        dr_zero = dz;
      end
      check($sformatf("%s_ctl_t%0d", name, k), 32'(ctrl), 32'(exp_q[k]));
      check($sformatf("%s_sc_t%0d", name, k), 32'(sc), k);
      if (k == 3) check($sformatf("%s_iflag", name), 32'(i_flag), 32'(ir_val[15]));
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_halted", 32'(halted), 0);
  endtask

  function automatic int instr_len(input logic [15:0] v);
    case (v[14:12])
      3'd0, 3'd1, 3'd2, 3'd5: return 6;
      3'd3, 3'd4:             return 5;
      3'd6:                   return 7;
      default:                return 4;
    endcase
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles, instr, expected_total, measured;
    logic done;
    logic [15:0] rv;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl", 32'(ctrl), 0);
    check("rst_sc", 32'(sc), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_iflag", 32'(i_flag), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ctrl", 32'(ctrl), 0);
    check("idle_sc", 32'(sc), 0);

    start_pulse();
    exp_q = '{C_T0, C_T1, C_T2, 17'h0, C_MRD, AC_LD | 17'd2, 17'h0};
    run_instr("lda_dir", 16'h2005, 1'b0, 6);
    exp_q = '{C_T0, C_T1, C_T2, C_IND, C_MRD, AC_LD | 17'd2, 17'h0};
    run_instr("lda_ind", 16'hA010, 1'b0, 6);
    exp_q = '{C_T0, C_T1, C_T2, 17'h0, C_MRD, DR_INR, S3 | WRITE | PC_INR};
    run_instr("isz_z", 16'h6020, 1'b1, 7);
    exp_q = '{C_T0, C_T1, C_T2, 17'h0, C_MRD, DR_INR, S3 | WRITE};
    run_instr("isz_nz", 16'h6020, 1'b0, 7);
    exp_q = '{C_T0, C_T1, C_T2, 17'h0, S2 | WRITE | AR_INR, S1 | PC_LD, 17'h0};
    run_instr("bsa", 16'h5030, 1'b0, 6);
    exp_q = '{C_T0, C_T1, C_T2, 17'h0, C_MRD, AC_LD | 17'd0, 17'h0};
    run_instr("and", 16'h0100, 1'b0, 6);
    exp_q = '{C_T0, C_T1, C_T2, C_IND, C_MRD, AC_LD | 17'd1, 17'h0};
    run_instr("add_ind", 16'h9100, 1'b0, 6);
    exp_q = '{C_T0, C_T1, C_T2, 17'h0, S1 | PC_LD, 17'h0, 17'h0};
    run_instr("bun", 16'h4050, 1'b0, 5);
    exp_q = '{C_T0, C_T1, C_T2, 17'h0, 17'h0, 17'h0, 17'h0};
    run_instr("regref", 16'h7800, 1'b0, 4);
    // Next instruction is back at T0
    @(negedge clk);
    check("regref_wrap_sc", 32'(sc), 0);
    check("regref_wrap_ctl", 32'(ctrl), 32'(C_T0));

    // HLT with a simultaneous start: halt must win
    exp_q = '{C_T1, C_T2, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0};
    ir = 16'h7001;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("hlt_ctl_t%0d", k), 32'(ctrl), 32'(exp_q[k-1]));
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hlt_halted", 32'(halted), 1);
    check("hlt_busy", 32'(busy), 0);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("hlt_quiet_ctl%0d", k), 32'(ctrl), 0);
      check($sformatf("hlt_quiet_sc%0d", k), 32'(sc), 0);
      @(negedge clk);
    end
    check("hlt_still_halted", 32'(halted), 1);
    start_pulse();

    // STA, reset asserted during T4 while write is high
    exp_q = '{C_T0, C_T1, C_T2, 17'h0, S4 | WRITE, 17'h0, 17'h0};
    run_instr("sta", 16'h3040, 1'b0, 5);
    #2 rst = 1'b1;
    #1;
    check("sta_rst_write", 32'(write), 0);
    check("sta_rst_ctl", 32'(ctrl), 0);
    check("sta_rst_sc", 32'(sc), 0);
    check("sta_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_ctl%0d", k), 32'(ctrl), 0);
    end

    // Random legal instruction stream
    start_pulse();
    cycles = 0;
    instr = 0;
    expected_total = 0;
    measured = 0;
    done = 1'b0;
    while (!done && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      check("rnd_rw_excl", 32'(read & write), 0);
      check("rnd_sc_max", 32'(sc <= 4'd6), 1);
      if (sc == 4'd0 && busy) begin
        if (instr == 200) begin
          measured = cycles - 1;
          done = 1'b1;
        end else begin
          if ($urandom_range(0, 7) == 7)
            rv = {1'($urandom_range(0, 1)), 3'b111, 12'(16'h1 << $urandom_range(1, 11))};
          else
            rv = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 6)), 12'($urandom)};
          ir = rv;
          dr_zero = 1'($urandom_range(0, 1));
          expected_total += instr_len(rv);
          instr++;
        end
      end
    end
    check("rnd_done", 32'(done), 1);
    check("rnd_total_cycles", measured, expected_total);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
